rv_bank_sched: RTL and testbench

- Per-bank input scheduler for the cache bank pipeline.
- Arbitrates the bank's single pipeline slot between four sources:
  - bank init/flush sweep
  - memory fill responses
  - miss-reservation (MSHR) replays
  - new core requests
- Gates core requests when the MSHR is near full, and guarantees core forward progress with a starvation counter.
- Sits between the bank's input queues / MSHR dequeue port and stage 0 of the bank pipeline.

---
 rtl/rv_bank_sched_pkg.sv | 18 +
 rtl/rv_bank_sched.sv | 140 ++++++++++++++
 tb/tb_rv_bank_sched.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_bank_sched_pkg.sv
// Shared encodings for the cache bank input scheduler: pipeline source select
// values and scheduler FSM states.
package rv_bank_sched_pkg;

    localparam logic [1:0] PIPE_SEL_FLUSH  = 2'd0;
    localparam logic [1:0] PIPE_SEL_FILL   = 2'd1;
    localparam logic [1:0] PIPE_SEL_REPLAY = 2'd2;
    localparam logic [1:0] PIPE_SEL_CORE   = 2'd3;

    localparam int STARVE_CNT_BITS = 8;

    typedef enum logic [1:0] {
        ST_INIT       = 2'd0,
        ST_IDLE       = 2'd1,
        ST_FLUSH_WAIT = 2'd2
    } sched_state_e;

endpackage

// File: rtl/rv_bank_sched.sv
// Per-bank input scheduler: owns the single stage-0 slot and shares it between
// the init/flush sweep, memory fills, MSHR replays and new core requests.
module rv_bank_sched
    import rv_bank_sched_pkg::*;
#(
    parameter int NUM_LINES       = 64,
    parameter int LINE_SEL_BITS   = $clog2(NUM_LINES),
    parameter int MSHR_SIZE       = 4,
    parameter int MSHR_ADDR_WIDTH = $clog2(MSHR_SIZE),
    parameter int STARVE_LIMIT    = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_start,
    input  logic                       mem_rsp_valid,
    input  logic [MSHR_ADDR_WIDTH-1:0] mem_rsp_id,
    output logic                       mem_rsp_ready,
    input  logic                       replay_valid,
    output logic                       replay_ready,
    input  logic                       core_req_valid,
    output logic                       core_req_ready,
    input  logic                       mshr_alm_full,
    input  logic                       mshr_pending,
    input  logic                       pipe_ready,
    output logic                       pipe_valid,
    output logic [1:0]                 pipe_sel,
    output logic [LINE_SEL_BITS-1:0]   pipe_flush_line,
    output logic                       fill_valid,
    output logic [MSHR_ADDR_WIDTH-1:0] fill_id,
    output logic                       init_done,
    output logic [1:0]                 dbg_state,
    output logic [STARVE_CNT_BITS-1:0] dbg_starve_cnt
);

    // Handshake: a source fires in the cycle its valid and its ready are both
    // high; readies are combinational, mutually exclusive and only high while
    // pipe_ready is high, so a ready always implies the op enters stage 0.

    localparam logic [STARVE_CNT_BITS-1:0] STARVE_MAX  = STARVE_CNT_BITS'(STARVE_LIMIT);
    localparam logic [LINE_SEL_BITS-1:0]   LAST_LINE   = LINE_SEL_BITS'(NUM_LINES - 1);

    sched_state_e                state_q, state_d;
    logic [LINE_SEL_BITS-1:0]    line_q, line_d;
    logic [STARVE_CNT_BITS-1:0]  starve_q, starve_d;

    logic core_elig;
    logic core_fire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_INIT;
            line_q   <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            line_q   <= line_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        line_d          = line_q;
        starve_d        = starve_q;
        mem_rsp_ready   = 1'b0;
        replay_ready    = 1'b0;
        core_req_ready  = 1'b0;
        pipe_valid      = 1'b0;
        pipe_sel        = PIPE_SEL_FLUSH;
        pipe_flush_line = '0;
        init_done       = 1'b0;
        core_elig       = 1'b0;
        core_fire       = 1'b0;

        if (!reset) begin
            unique case (state_q)
                ST_INIT: begin
                    pipe_valid      = 1'b1;
                    pipe_sel        = PIPE_SEL_FLUSH;
                    pipe_flush_line = line_q;
                    if (pipe_ready) begin
                        if (line_q == LAST_LINE) begin
                            state_d = ST_IDLE;
                            line_d  = '0;
                        end else begin
                            line_d = line_q + 1'b1;
                        end
                    end
                end
                ST_IDLE, ST_FLUSH_WAIT: begin
                    init_done = 1'b1;
                    core_elig = !mshr_alm_full && (state_q == ST_IDLE);
                    // Starvation override may jump core ahead of replay, never ahead of a fill.
                    if (pipe_ready) begin
                        if (mem_rsp_valid) begin
                            mem_rsp_ready = 1'b1;
                            pipe_sel      = PIPE_SEL_FILL;
                        end else if (core_req_valid && core_elig && starve_q == STARVE_MAX) begin
                            core_req_ready = 1'b1;
                            pipe_sel       = PIPE_SEL_CORE;
                        end else if (replay_valid) begin
                            replay_ready = 1'b1;
                            pipe_sel     = PIPE_SEL_REPLAY;
                        end else if (core_req_valid && core_elig) begin
                            core_req_ready = 1'b1;
                            pipe_sel       = PIPE_SEL_CORE;
                        end
                    end
                    pipe_valid = mem_rsp_ready | replay_ready | core_req_ready;
                    core_fire  = core_req_valid & core_req_ready;

                    if (state_q == ST_IDLE) begin
                        if (flush_start) begin
                            state_d = mshr_pending ? ST_FLUSH_WAIT : ST_INIT;
                        end
                    end else if (!mshr_pending) begin
                        // Outstanding misses have all filled; safe to sweep the bank.
                        state_d = ST_INIT;
                    end
                end
                default: begin
                    state_d = ST_INIT;
                    line_d  = '0;
                end
            endcase

            if (!core_req_valid || core_fire) begin
                starve_d = '0;
            end else if (core_elig && starve_q != STARVE_MAX) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    assign fill_valid     = mem_rsp_valid & mem_rsp_ready;
    assign fill_id        = reset ? '0 : mem_rsp_id;
    assign dbg_state      = reset ? 2'd0 : state_q;
    assign dbg_starve_cnt = reset ? '0 : starve_q;

endmodule

// File: tb/tb_rv_bank_sched.sv
// Directed bench for rv_bank_sched: init sweep, arbitration, starvation,
// near-full gating, flush wait and mid-sweep reset.
module tb_rv_bank_sched;
  import rv_bank_sched_pkg::*;

  localparam int NUM_LINES = 64;
  localparam int LSB = 6;
  localparam int MAW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           flush_start;
  logic           mem_rsp_valid;
  logic [MAW-1:0] mem_rsp_id;
  logic           mem_rsp_ready;
  logic           replay_valid;
  logic           replay_ready;
  logic           core_req_valid;
  logic           core_req_ready;
  logic           mshr_alm_full;
  logic           mshr_pending;
  logic           pipe_ready;
  logic           pipe_valid;
  logic [1:0]     pipe_sel;
  logic [LSB-1:0] pipe_flush_line;
  logic           fill_valid;
  logic [MAW-1:0] fill_id;
  logic           init_done;
  logic [1:0]     dbg_state;
  logic [7:0]     dbg_starve_cnt;

  int checks = 0;
  int errors = 0;

  rv_bank_sched #(
    .NUM_LINES(NUM_LINES),
    .MSHR_SIZE(4),
    .STARVE_LIMIT(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush_start(flush_start),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_id(mem_rsp_id),
    .mem_rsp_ready(mem_rsp_ready),
    .replay_valid(replay_valid),
    .replay_ready(replay_ready),
    .core_req_valid(core_req_valid),
    .core_req_ready(core_req_ready),
    .mshr_alm_full(mshr_alm_full),
    .mshr_pending(mshr_pending),
    .pipe_ready(pipe_ready),
    .pipe_valid(pipe_valid),
    .pipe_sel(pipe_sel),
    .pipe_flush_line(pipe_flush_line),
    .fill_valid(fill_valid),
    .fill_id(fill_id),
    .init_done(init_done),
    .dbg_state(dbg_state),
    .dbg_starve_cnt(dbg_starve_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_grants(input string tag, input logic f, input logic r, input logic c,
                            input logic [1:0] sel);
    chk({tag, ".mem_rsp_ready"}, 32'(mem_rsp_ready), 32'(f));
    chk({tag, ".replay_ready"}, 32'(replay_ready), 32'(r));
    chk({tag, ".core_req_ready"}, 32'(core_req_ready), 32'(c));
    chk({tag, ".pipe_valid"}, 32'(pipe_valid), 32'(f | r | c));
    if (f | r | c) chk({tag, ".pipe_sel"}, 32'(pipe_sel), 32'(sel));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".pipe_valid"}, 32'(pipe_valid), 32'd0);
    chk({tag, ".readies"}, 32'({mem_rsp_ready, replay_ready, core_req_ready}), 32'd0);
    chk({tag, ".fill_valid"}, 32'(fill_valid), 32'd0);
    chk({tag, ".pipe_sel"}, 32'(pipe_sel), 32'd0);
    chk({tag, ".flush_line"}, 32'(pipe_flush_line), 32'd0);
    chk({tag, ".init_done"}, 32'(init_done), 32'd0);
  endtask

  // Runs a sweep of n cycles with pipe_ready held high, checking lines from start.
  task automatic sweep(input string tag, input int start, input int n);
    for (int i = 0; i < n; i++) begin
      pipe_ready = 1'b1;
      settle();
      chk({tag, ".valid"}, 32'(pipe_valid), 32'd1);
      chk({tag, ".sel"}, 32'(pipe_sel), 32'(PIPE_SEL_FLUSH));
      chk({tag, ".line"}, 32'(pipe_flush_line), 32'(start + i));
      chk({tag, ".init_done"}, 32'(init_done), 32'd0);
      next_cycle();
    end
  endtask

  initial begin
    int exp_line;
    reset = 1'b1; flush_start = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_id = '0;
    replay_valid = 1'b0; core_req_valid = 1'b0; mshr_alm_full = 1'b0;
    mshr_pending = 1'b0; pipe_ready = 1'b1;

    // Reset: every output held at zero even with sources pending.
    next_cycle();
    mem_rsp_valid = 1'b1; replay_valid = 1'b1; core_req_valid = 1'b1;
    settle();
    chk_all_zero("reset");
    mem_rsp_valid = 1'b0; replay_valid = 1'b0; core_req_valid = 1'b0;
    next_cycle();
    reset = 1'b0;

    // Init sweep with a 3-cycle pipe_ready drop at cycle 10: 67 cycles total.
    exp_line = 0;
    for (int c = 0; c < 67; c++) begin
      pipe_ready = (c >= 10 && c < 13) ? 1'b0 : 1'b1;
      settle();
      chk("init.valid", 32'(pipe_valid), 32'd1);
      chk("init.sel", 32'(pipe_sel), 32'(PIPE_SEL_FLUSH));
      chk("init.line", 32'(pipe_flush_line), 32'(exp_line));
      chk("init.init_done", 32'(init_done), 32'd0);
      chk("init.readies", 32'({mem_rsp_ready, replay_ready, core_req_ready}), 32'd0);
      if (pipe_ready) exp_line++;
      next_cycle();
    end
    pipe_ready = 1'b1;
    settle();
    chk("idle.init_done", 32'(init_done), 32'd1);
    chk("idle.state", 32'(dbg_state), 32'(ST_IDLE));
    chk("idle.pipe_valid", 32'(pipe_valid), 32'd0);
    next_cycle();

    // Fill beats replay and core.
    mshr_pending = 1'b1;
    mem_rsp_valid = 1'b1; mem_rsp_id = 2'd2; replay_valid = 1'b1; core_req_valid = 1'b1;
    settle();
    chk_grants("fill", 1'b1, 1'b0, 1'b0, PIPE_SEL_FILL);
    chk("fill.fill_valid", 32'(fill_valid), 32'd1);
    chk("fill.fill_id", 32'(fill_id), 32'd2);
    next_cycle();
    mem_rsp_valid = 1'b0;
    settle();
    chk_grants("after_fill", 1'b0, 1'b1, 1'b0, PIPE_SEL_REPLAY);
    chk("after_fill.fill_valid", 32'(fill_valid), 32'd0);
    next_cycle();

    // pipe_ready low blocks everything.
    pipe_ready = 1'b0; mem_rsp_valid = 1'b1;
    settle();
    chk_grants("stall", 1'b0, 1'b0, 1'b0, PIPE_SEL_FLUSH);
    chk("stall.fill_valid", 32'(fill_valid), 32'd0);
    next_cycle();
    pipe_ready = 1'b1; mem_rsp_valid = 1'b0;

    // Drop core valid for a cycle so the starvation count restarts at zero.
    core_req_valid = 1'b0;
    next_cycle();
    settle();
    chk("starve.cleared", 32'(dbg_starve_cnt), 32'd0);

    // 8 replays then one forced core grant, twice over.
    core_req_valid = 1'b1;
    for (int i = 0; i < 18; i++) begin
      settle();
      chk("starve.cnt", 32'(dbg_starve_cnt), 32'(i % 9));
      if (i % 9 == 8) chk_grants("starve.core", 1'b0, 1'b0, 1'b1, PIPE_SEL_CORE);
      else            chk_grants("starve.replay", 1'b0, 1'b1, 1'b0, PIPE_SEL_REPLAY);
      next_cycle();
    end
    settle();
    chk("starve.reset_after_core", 32'(dbg_starve_cnt), 32'd0);

    // Near-full MSHR: core held off without counting as starvation.
    mshr_alm_full = 1'b1;
    for (int i = 0; i < 20; i++) begin
      settle();
      chk_grants("almfull", 1'b0, 1'b1, 1'b0, PIPE_SEL_REPLAY);
      chk("almfull.cnt", 32'(dbg_starve_cnt), 32'd0);
      next_cycle();
    end
    mshr_alm_full = 1'b0;
    replay_valid = 1'b0;
    settle();
    chk_grants("core_alone", 1'b0, 1'b0, 1'b1, PIPE_SEL_CORE);
    next_cycle();

    // flush_start alongside a fill fire: fill completes, FSM waits for the MSHR.
    core_req_valid = 1'b0;
    flush_start = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_id = 2'd1;
    settle();
    chk_grants("flush.fill", 1'b1, 1'b0, 1'b0, PIPE_SEL_FILL);
    chk("flush.fill_id", 32'(fill_id), 32'd1);
    next_cycle();
    flush_start = 1'b0; mem_rsp_valid = 1'b0; core_req_valid = 1'b1;
    settle();
    chk("fwait.state", 32'(dbg_state), 32'(ST_FLUSH_WAIT));
    chk("fwait.init_done", 32'(init_done), 32'd1);
    chk_grants("fwait.core_blocked", 1'b0, 1'b0, 1'b0, PIPE_SEL_FLUSH);
    next_cycle();
    mem_rsp_valid = 1'b1; mem_rsp_id = 2'd3;
    settle();
    chk_grants("fwait.fill", 1'b1, 1'b0, 1'b0, PIPE_SEL_FILL);
    chk("fwait.fill_id", 32'(fill_id), 32'd3);
    next_cycle();
    mem_rsp_valid = 1'b0; replay_valid = 1'b1;
    settle();
    chk_grants("fwait.replay", 1'b0, 1'b1, 1'b0, PIPE_SEL_REPLAY);
    next_cycle();
    replay_valid = 1'b0; core_req_valid = 1'b0; mshr_pending = 1'b0;
    settle();
    chk("fwait.last_cycle", 32'(dbg_state), 32'(ST_FLUSH_WAIT));
    next_cycle();

    // Sweep from line 0 and reset at line 30.
    sweep("flush_sweep", 0, 30);
    reset = 1'b1;
    settle();
    chk_all_zero("midreset");
    next_cycle();
    reset = 1'b0;
    sweep("restart", 0, 64);
    settle();
    chk("restart.init_done", 32'(init_done), 32'd1);

    // flush_start with no pending misses goes straight to the sweep.
    flush_start = 1'b1;
    next_cycle();
    flush_start = 1'b0;
    sweep("direct_flush", 0, 4);
    chk("direct_flush.state", 32'(dbg_state), 32'(ST_INIT));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
